toysram_ra_bridge: RTL
======================

// Module: toysram_ra_bridge
// PURPOSE
//  Parametrised command-to-array bridge for the toysram site; next generation of the single-array control path.
//  Takes decoded array-space commands from cfg and routes them to one of NUM_RA register arrays.
//  Each array has a 1R1W port and a programmable read latency.
//  Adds partial-byte writes by read-modify-write, out-of-range array error, and explicit write ack.
// PARAMETERS
//  NUM_RA  4             number of attached arrays (1..16)
//  DAT_W   32            array data width; multiple of 8
//  ADR_W   5             entry address width per array (depth = 2**ADR_W)
//  RD_LAT  1             cycles from ra_rd_enb to valid ra_rd_dat (1..4)
//  ERR_DAT 32'hBADACCE5  read data returned for an out-of-range array
// PORTS
//  clk         in   1             site clock
//  rst         in   1             asynchronous reset, active high
//  cmd_val     in   1             one-cycle command strobe; honoured only when busy=0
//  cmd_we      in   1             1=write, 0=read
//  cmd_adr     in   32            byte address within RA space
//  cmd_sel     in   DAT_W/8       byte enables (writes only)
//  cmd_dat     in   DAT_W         write data
//  busy        out  1             command in flight
//  rd_ack      out  1             one-cycle read completion
//  rd_dat      out  DAT_W         read data, valid with rd_ack; held until next rd_ack
//  wr_ack      out  1             one-cycle write completion
//  err         out  1             pulses with rd_ack/wr_ack when array index >= NUM_RA
//  ra_rd_enb   out  NUM_RA        per-array read enable (one-hot or zero)
//  ra_rd_adr   out  ADR_W         shared read address
//  ra_rd_dat   in   NUM_RA*DAT_W  concatenated read data; array i at [i*DAT_W +: DAT_W]
//  ra_wr_enb   out  NUM_RA        per-array write enable (one-hot or zero)
//  ra_wr_adr   out  ADR_W         shared write address
//  ra_wr_dat   out  DAT_W         shared write data
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, latency counter 0; async assert, sync release.
//  - Decode: entry = cmd_adr[ADR_W+1:2]; array = cmd_adr[ADR_W+5:ADR_W+2] (4 bits).
//    Both are latched at accept (cycle T).
//  - FSM states: IDLE, RD, RMW, WR, DONE.
//  - IDLE: cmd_val && !busy -> accept at T; busy=1 from T+1.
//  - Read: RD; ra_rd_enb[array] high at T+1 only; counter counts RD_LAT.
//    Data is sampled at T+1+RD_LAT; rd_ack and rd_dat at T+2+RD_LAT; back to IDLE.
//  - Write, sel all-ones: WR; ra_wr_enb and wr_ack both at T+1; IDLE at T+2.
//  - Write, sel partial nonzero: RMW read as above.
//    At T+1+RD_LAT merge bytewise (sel ? cmd_dat : old).
//    ra_wr_enb and wr_ack at T+2+RD_LAT; no rd_ack.
//  - Write, sel zero: no array access; wr_ack at T+1.
//  - Out-of-range array: no array enable.
//    Read: rd_dat=ERR_DAT at T+2+RD_LAT. Write: wr_ack at T+1. err pulses with the ack.
//  - cmd_val while busy: ignored, no state change; upstream must not issue.
//  - busy deasserts the cycle after the ack; a new cmd_val is accepted the same cycle busy=0.
//  - Read data is muxed from the latched array index, never live cmd_adr.
//  - Reset mid-operation: enables drop immediately, no ack issued, pending command discarded.
// STRUCTURE
//  - toysram.vh: FSM state encodings, RA_SEL_W=4, default ERR_DAT.
//  - Sub-module toysram_ra_rdmux: NUM_RA:1 read-data mux, with ERR_DAT substitution for out-of-range.
//  - Everything else stays in one always block plus output regs.
// TESTING
//  1. Full write then read.
//     NUM_RA=4, RD_LAT=1: write adr 0x0000_0008, sel F, dat 0x12345678, then read same.
//     -> ra_wr_enb=0001 at T+1, wr_ack T+1; read rd_ack at T+3, rd_dat 0x12345678.
//  2. RMW.
//     Entry holds 0xAABBCCDD; write sel 4'b0101, dat 0x11223344.
//     -> one ra_rd_enb, then ra_wr_dat 0xAA22CC44; read back 0xAA22CC44.
//  3. Array select.
//     Write distinct values to entry 3 of arrays 0..3 (adr 0x0C|i<<7), then read each.
//     -> values match; no cross-write.
//  4. Out of range.
//     Read array 5 -> rd_ack, rd_dat 0xBADACCE5, err=1, ra_rd_enb never set.
//     Write array 5 -> wr_ack+err at T+1.
//  5. Latency sweep RD_LAT=3.
//     Read -> rd_ack exactly T+5.
//     Back-to-back reads accepted on the busy-low cycle.
//     cmd_val while busy ignored.
//  6. Reset mid-RMW.
//     Assert rst at T+2 -> all enables/acks 0 that cycle; entry unchanged; next read OK.

Source files
------------

// File: rtl/toysram_ra_bridge_pkg.sv
// Shared definitions for the toysram register-array bridge: FSM state
// encodings, array-select width and the default out-of-range read pattern.
package toysram_ra_bridge_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_RMW  = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam int RA_SEL_W = 4;

    localparam logic [31:0] ERR_DAT_DEFAULT = 32'hBADACCE5;

endpackage

// File: rtl/toysram_ra_rdmux.sv
// NUM_RA:1 read-data mux; any select outside the attached arrays returns the
// fixed error pattern instead of data.
module toysram_ra_rdmux
    import toysram_ra_bridge_pkg::*;
#(
    parameter int                NUM_RA  = 4,
    parameter int                DAT_W   = 32,
    parameter logic [DAT_W-1:0]  ERR_DAT = DAT_W'(ERR_DAT_DEFAULT)
) (
    input  logic [NUM_RA*DAT_W-1:0] ra_rd_dat,
    input  logic [RA_SEL_W-1:0]     ra_sel,
    output logic [DAT_W-1:0]        rd_dat
);

    always_comb begin
        rd_dat = ERR_DAT;
        for (int i = 0; i < NUM_RA; i++) begin
            if (ra_sel == RA_SEL_W'(i)) begin
                rd_dat = ra_rd_dat[i*DAT_W +: DAT_W];
            end
        end
    end

endmodule

// File: rtl/toysram_ra_bridge.sv
// Command-to-array bridge: routes decoded array-space reads/writes from cfg to
// one of NUM_RA 1R1W register arrays, with read-modify-write for partial writes.
module toysram_ra_bridge
    import toysram_ra_bridge_pkg::*;
#(
    parameter int                NUM_RA  = 4,
    parameter int                DAT_W   = 32,
    parameter int                ADR_W   = 5,
    parameter int                RD_LAT  = 1,
    parameter logic [DAT_W-1:0]  ERR_DAT = DAT_W'(ERR_DAT_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_val,
    input  logic                    cmd_we,
    input  logic [31:0]             cmd_adr,
    input  logic [DAT_W/8-1:0]      cmd_sel,
    input  logic [DAT_W-1:0]        cmd_dat,
    output logic                    busy,
    output logic                    rd_ack,
    output logic [DAT_W-1:0]        rd_dat,
    output logic                    wr_ack,
    output logic                    err,
    output logic [NUM_RA-1:0]       ra_rd_enb,
    output logic [ADR_W-1:0]        ra_rd_adr,
    input  logic [NUM_RA*DAT_W-1:0] ra_rd_dat,
    output logic [NUM_RA-1:0]       ra_wr_enb,
    output logic [ADR_W-1:0]        ra_wr_adr,
    output logic [DAT_W-1:0]        ra_wr_dat
);

    localparam int SEL_W = DAT_W / 8;

    state_t                 state;
    logic [2:0]             lat_cnt;
    logic [RA_SEL_W-1:0]    ra_q;
    logic                   oor_q;
    logic [SEL_W-1:0]       sel_q;
    logic [DAT_W-1:0]       dat_q;
    logic [DAT_W-1:0]       mux_dat;
    logic [DAT_W-1:0]       merged;
    logic [ADR_W-1:0]       cmd_entry;
    logic [RA_SEL_W-1:0]    cmd_ra;
    logic                   cmd_oor;
    logic                   unused_adr_bits;

    function automatic logic [NUM_RA-1:0] ra_onehot(input logic [RA_SEL_W-1:0] idx);
        ra_onehot = NUM_RA'(1) << idx;
    endfunction

    assign cmd_entry       = cmd_adr[ADR_W+1:2];
    assign cmd_ra          = cmd_adr[ADR_W+5:ADR_W+2];
    assign cmd_oor         = (int'(cmd_ra) >= NUM_RA);
    assign unused_adr_bits = ^{cmd_adr[31:ADR_W+6], cmd_adr[1:0]};
    assign busy            = (state != ST_IDLE);

    toysram_ra_rdmux #(
        .NUM_RA  (NUM_RA),
        .DAT_W   (DAT_W),
        .ERR_DAT (ERR_DAT)
    ) u_rdmux (
        .ra_rd_dat (ra_rd_dat),
        .ra_sel    (ra_q),
        .rd_dat    (mux_dat)
    );

    // Bytes with their enable set take the new data; the rest keep the array contents.
    always_comb begin
        merged = mux_dat;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel_q[b]) begin
                merged[b*8 +: 8] = dat_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            ra_q      <= '0;
            oor_q     <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            rd_ack    <= 1'b0;
            rd_dat    <= '0;
            wr_ack    <= 1'b0;
            err       <= 1'b0;
            ra_rd_enb <= '0;
            ra_rd_adr <= '0;
            ra_wr_enb <= '0;
            ra_wr_adr <= '0;
            ra_wr_dat <= '0;
        end else begin
            rd_ack    <= 1'b0;
            wr_ack    <= 1'b0;
            err       <= 1'b0;
            ra_rd_enb <= '0;
            ra_wr_enb <= '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_val) begin
                        ra_q      <= cmd_ra;
                        oor_q     <= cmd_oor;
                        sel_q     <= cmd_sel;
                        dat_q     <= cmd_dat;
                        lat_cnt   <= '0;
                        ra_rd_adr <= cmd_entry;
                        ra_wr_adr <= cmd_entry;
                        // Out-of-range reads still wait the full latency so timing is uniform.
                        if (cmd_oor && cmd_we) begin
                            wr_ack <= 1'b1;
                            err    <= 1'b1;
                            state  <= ST_DONE;
                        end else if (cmd_oor) begin
                            state <= ST_RD;
                        end else if (!cmd_we) begin
                            ra_rd_enb <= ra_onehot(cmd_ra);
                            state     <= ST_RD;
                        end else if (&cmd_sel) begin
                            ra_wr_enb <= ra_onehot(cmd_ra);
                            ra_wr_dat <= cmd_dat;
                            wr_ack    <= 1'b1;
                            state     <= ST_WR;
                        end else if (cmd_sel == '0) begin
                            wr_ack <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            ra_rd_enb <= ra_onehot(cmd_ra);
                            state     <= ST_RMW;
                        end
                    end
                end
                ST_RD: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == 3'(RD_LAT)) begin
                        rd_ack <= 1'b1;
                        rd_dat <= mux_dat;
                        err    <= oor_q;
                        state  <= ST_DONE;
                    end
                end
                ST_RMW: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == 3'(RD_LAT)) begin
                        ra_wr_enb <= ra_onehot(ra_q);
                        ra_wr_dat <= merged;
                        wr_ack    <= 1'b1;
                        state     <= ST_WR;
                    end
                end
                ST_WR, ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
